// File: rtl/data_cache_pkg.sv
// Shared types and address-split helpers for the direct-mapped data cache.
package data_cache_pkg;

  localparam int ADDR_W = 32;
  localparam int OFF_W  = 2;

  typedef enum logic [1:0] {
    IDLE,
    READ_MISS,
    WRITE
  } state_t;

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int lines);
    return ADDR_W - OFF_W - $clog2(lines);
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Tag/valid/data arrays: one combinational read port, one synchronous write port.
module cache_line_store #(
  parameter int LINES = 32,
  parameter int IB    = 5,
  parameter int TAG_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IB-1:0]    rd_index,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IB-1:0]    wr_index,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data
);

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags  [LINES];
  logic [31:0]      words [LINES];

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_data  = words[rd_index];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // Payload arrays carry no reset; valid alone gates their use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_index]  <= wr_tag;
      words[wr_index] <= wr_data;
    end
  end

endmodule

// File: rtl/data_cache.sv
// Write-through, no-write-allocate direct-mapped data cache for the MEM stage.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int LINES       = 32,
  parameter int MEM_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_write_data,
  output logic [31:0] cpu_read_data,
  output logic        stall,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int IB = idx_w(LINES);
  localparam int TW = tag_w(LINES);
  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_LATENCY - 1);

  state_t state, state_nx;
  logic [CW-1:0] cnt;

  logic [IB-1:0] index;
  logic [TW-1:0] tag;
  logic          line_valid;
  logic [TW-1:0] line_tag;
  logic [31:0]   line_data;
  logic          hit;
  logic          is_read;

  logic          line_we;
  logic [31:0]   line_wdata;
  logic          cnt_clr;
  logic          cnt_inc;
  logic          hit_inc;
  logic          miss_inc;
  logic          unused_ok;

  assign index     = cpu_address[OFF_W+IB-1:OFF_W];
  assign tag       = cpu_address[ADDR_W-1:OFF_W+IB];
  assign unused_ok = ^cpu_address[OFF_W-1:0];
  assign hit       = line_valid && (line_tag == tag);
  assign is_read   = cpu_read && !cpu_write;

  cache_line_store #(
    .LINES (LINES),
    .IB    (IB),
    .TAG_W (TW)
  ) u_store (
    .clk      (clk),
    .rst      (rst),
    .rd_index (index),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (line_we),
    .wr_index (index),
    .wr_tag   (tag),
    .wr_data  (line_wdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (cnt_inc) begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_inc)  hit_count  <= hit_count + 32'd1;
      if (miss_inc) miss_count <= miss_count + 32'd1;
    end
  end

  always_comb begin
    state_nx       = state;
    stall          = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    cpu_read_data  = '0;
    line_we        = 1'b0;
    line_wdata     = '0;
    cnt_clr        = 1'b0;
    cnt_inc        = 1'b0;
    hit_inc        = 1'b0;
    miss_inc       = 1'b0;
    unique case (state)
      IDLE: begin
        if (cpu_write) begin
          stall    = 1'b1;
          state_nx = WRITE;
        end else if (is_read && hit) begin
          cpu_read_data = line_data;
          hit_inc       = 1'b1;
        end else if (is_read) begin
          stall    = 1'b1;
          miss_inc = 1'b1;
          cnt_clr  = 1'b1;
          state_nx = READ_MISS;
        end
      end
      READ_MISS: begin
        mem_read    = 1'b1;
        mem_address = cpu_address;
        cnt_inc     = 1'b1;
        if (cnt == LAST) begin
          cpu_read_data = mem_read_data;
          line_we       = 1'b1;
          line_wdata    = mem_read_data;
          state_nx      = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      WRITE: begin
        mem_write      = 1'b1;
        mem_address    = cpu_address;
        mem_write_data = cpu_write_data;
        line_we        = hit;
        line_wdata     = cpu_write_data;
        state_nx       = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Reset must silence the bus at once, even mid-transaction.
    if (rst) begin
      stall         = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      cpu_read_data = '0;
      line_we       = 1'b0;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache (LINES=32, MEM_LATENCY=4).
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_address, cpu_write_data, cpu_read_data;
  logic        stall, mem_read, mem_write;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic [31:0] hit_count, miss_count;

  int checks = 0;
  int errors = 0;

  int          n_stall, n_mrd, n_mwr;
  logic [31:0] rdata, waddr, wdata;

  always #5 clk = ~clk;

  data_cache #(.LINES(32), .MEM_LATENCY(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_read       (cpu_read),
    .cpu_write      (cpu_write),
    .cpu_address    (cpu_address),
    .cpu_write_data (cpu_write_data),
    .cpu_read_data  (cpu_read_data),
    .stall          (stall),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] word);
    bit done = 0;
    cpu_read      = 1'b1;
    cpu_write     = 1'b0;
    cpu_address   = addr;
    mem_read_data = word;
    n_stall = 0;
    n_mrd   = 0;
    rdata   = 'x;
    for (int i = 0; i < 20 && !done; i++) begin
      #2;
      if (stall === 1'b1) n_stall++;
      if (mem_read === 1'b1) n_mrd++;
      if (stall === 1'b0) begin
        rdata = cpu_read_data;
        done  = 1;
      end
      step();
    end
    cpu_read = 1'b0;
    if (!done) chk("read_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] d,
                          input logic also_rd);
    bit done = 0;
    cpu_read       = also_rd;
    cpu_write      = 1'b1;
    cpu_address    = addr;
    cpu_write_data = d;
    n_stall = 0;
    n_mwr   = 0;
    n_mrd   = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      #2;
      if (stall === 1'b1) n_stall++;
      if (mem_read === 1'b1) n_mrd++;
      if (mem_write === 1'b1) begin
        n_mwr++;
        waddr = mem_address;
        wdata = mem_write_data;
      end
      if (stall === 1'b0) done = 1;
      step();
    end
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    if (!done) chk("write_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst            = 1'b1;
    cpu_read       = 1'b1;
    cpu_write      = 1'b0;
    cpu_address    = 32'h400;
    cpu_write_data = '0;
    mem_read_data  = '0;
    step();
    step();
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_misses", miss_count, 32'd0);
    cpu_read = 1'b0;
    rst      = 1'b0;
    step();

    do_read(32'h400, 32'h12345678);
    chk("miss1_stall_cycles", n_stall, 32'd4);
    chk("miss1_mem_read_cycles", n_mrd, 32'd4);
    chk("miss1_data", rdata, 32'h12345678);
    chk("miss1_miss_count", miss_count, 32'd1);
    chk("miss1_hit_count", hit_count, 32'd0);
    #2;
    chk("idle_mem_read", {31'd0, mem_read}, 32'd0);
    chk("idle_read_data", cpu_read_data, 32'd0);
    step();

    do_read(32'h400, 32'hFFFFFFFF);
    chk("hit1_stall", n_stall, 32'd0);
    chk("hit1_mem_read", n_mrd, 32'd0);
    chk("hit1_data", rdata, 32'h12345678);
    chk("hit1_hit_count", hit_count, 32'd1);

    do_write(32'h400, 32'hDEADBEEF, 1'b0);
    chk("wr1_stall", n_stall, 32'd1);
    chk("wr1_mem_write", n_mwr, 32'd1);
    chk("wr1_addr", waddr, 32'h400);
    chk("wr1_data", wdata, 32'hDEADBEEF);
    #2;
    chk("wr1_idle_mem_write", {31'd0, mem_write}, 32'd0);
    step();
    do_read(32'h400, 32'h0);
    chk("wr1_hit_data", rdata, 32'hDEADBEEF);
    chk("wr1_hit_stall", n_stall, 32'd0);
    chk("wr1_hit_count", hit_count, 32'd2);

    do_write(32'h800, 32'hCAFEF00D, 1'b0);
    chk("wr2_mem_write", n_mwr, 32'd1);
    chk("wr2_data", wdata, 32'hCAFEF00D);
    do_read(32'h400, 32'h0);
    chk("wr2_line_kept", rdata, 32'hDEADBEEF);
    chk("wr2_hit_count", hit_count, 32'd3);
    do_read(32'h800, 32'hCAFEF00D);
    chk("wr2_read_miss", miss_count, 32'd2);
    chk("wr2_read_stalls", n_stall, 32'd4);
    chk("wr2_read_data", rdata, 32'hCAFEF00D);

    do_read(32'h400, 32'h11111111);
    chk("cf_fill_miss", miss_count, 32'd3);
    do_read(32'h480, 32'h22222222);
    chk("cf_480_miss", miss_count, 32'd4);
    chk("cf_480_data", rdata, 32'h22222222);
    do_read(32'h400, 32'h33333333);
    chk("cf_400_remiss", miss_count, 32'd5);
    chk("cf_400_data", rdata, 32'h33333333);
    chk("cf_hit_count", hit_count, 32'd3);

    do_write(32'h400, 32'h55AA55AA, 1'b1);
    chk("rw_stall", n_stall, 32'd1);
    chk("rw_mem_write", n_mwr, 32'd1);
    chk("rw_mem_read", n_mrd, 32'd0);
    chk("rw_hits", hit_count, 32'd3);
    chk("rw_misses", miss_count, 32'd5);
    do_read(32'h400, 32'h0);
    chk("rw_hit_data", rdata, 32'h55AA55AA);
    chk("rw_hit_count", hit_count, 32'd4);

    cpu_read      = 1'b1;
    cpu_address   = 32'h404;
    mem_read_data = 32'h77777777;
    step();
    step();
    step();
    #2;
    chk("rm_mem_read_pre", {31'd0, mem_read}, 32'd1);
    chk("rm_stall_pre", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rm_mem_read_rst", {31'd0, mem_read}, 32'd0);
    chk("rm_stall_rst", {31'd0, stall}, 32'd0);
    chk("rm_data_rst", cpu_read_data, 32'd0);
    chk("rm_misses_rst", miss_count, 32'd0);
    cpu_read = 1'b0;
    step();
    rst = 1'b0;
    step();
    do_read(32'h400, 32'h99999999);
    chk("post_rst_miss", miss_count, 32'd1);
    chk("post_rst_stalls", n_stall, 32'd4);
    chk("post_rst_data", rdata, 32'h99999999);

    cpu_write      = 1'b1;
    cpu_address    = 32'h40C;
    cpu_write_data = 32'h1;
    step();
    #2;
    chk("wr_state_mem_write", {31'd0, mem_write}, 32'd1);
    rst = 1'b1;
    #1;
    chk("wr_rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("wr_rst_stall", {31'd0, stall}, 32'd0);
    cpu_write = 1'b0;
    step();
    rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
